// File: rtl/bitcast_pkg.sv
// -----------------------------------------------------------------------------
// bitcast_pkg
// Shared types and constants for the bitcast engine:
//   - bitcast_cmd_t   : packed 113-bit command word
//   - bitcast_state_e : controller states
//   - STATUS_*        : completion status codes reported on done_status
//   - helpers for element-size validation and extent selection
// -----------------------------------------------------------------------------
package bitcast_pkg;

  localparam int CMD_W   = 113;
  localparam int DIM_W   = 10;
  localparam int CNT_W   = 40;
  localparam int BYTES_W = 43;

  // [112:108] sub_op, [107:68] src_dim, [67:28] dst_dim, [27:17] src_addr,
  // [16:6] dst_addr, [5:3] in_size, [2:0] out_size
  typedef struct packed {
    logic [4:0]  sub_op;
    logic [39:0] src_dim;
    logic [39:0] dst_dim;
    logic [10:0] src_addr;
    logic [10:0] dst_addr;
    logic [2:0]  in_size;
    logic [2:0]  out_size;
  } bitcast_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_CHECK = 3'd2,
    ST_COPY  = 3'd3,
    ST_DONE  = 3'd4
  } bitcast_state_e;

  localparam logic [1:0] STATUS_OK            = 2'd0;
  localparam logic [1:0] STATUS_SIZE_MISMATCH = 2'd1;
  localparam logic [1:0] STATUS_BAD_ELEM      = 2'd2;
  localparam logic [1:0] STATUS_RANGE         = 2'd3;

  // Size code c means 2^c bytes; only 1, 2, 4 and 8 byte elements exist.
  function automatic logic elem_size_ok(input logic [2:0] code);
    return code <= 3'd3;
  endfunction

  // Extent idx of a packed dimension field, dim0 in the low bits.
  function automatic logic [DIM_W-1:0] dim_sel(input logic [39:0] dims,
                                               input logic [1:0]  idx);
    logic [DIM_W-1:0] ext;
    case (idx)
      2'd0:    ext = dims[9:0];
      2'd1:    ext = dims[19:10];
      2'd2:    ext = dims[29:20];
      default: ext = dims[39:30];
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/bitcast_size_calc.sv
// -----------------------------------------------------------------------------
// bitcast_size_calc
// Element-count accumulation and command validation for the bitcast engine.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   i_start        : command accepted; reload both accumulators with 1
//   i_calc         : multiply in extent i_step of src and dst dimensions
//   i_step         : extent index 0..3 for the current multiply
//   i_cmd          : registered command
//   o_status       : status code, valid once all four extents are folded in
//   o_words        : 64-bit words needed to hold the source bytes (rounded up)
// -----------------------------------------------------------------------------
module bitcast_size_calc
  import bitcast_pkg::*;
#(
  parameter int MEM_AW = 11
)
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic               i_calc,
  input  logic [1:0]         i_step,
  input  bitcast_cmd_t       i_cmd,
  output logic [1:0]         o_status,
  output logic [BYTES_W-1:0] o_words
);

  logic [CNT_W-1:0]   r_src_cnt;
  logic [CNT_W-1:0]   r_dst_cnt;
  logic [DIM_W-1:0]   w_src_ext;
  logic [DIM_W-1:0]   w_dst_ext;
  logic [BYTES_W-1:0] w_src_bytes;
  logic [BYTES_W-1:0] w_dst_bytes;
  logic [BYTES_W-1:0] w_src_lim;
  logic [BYTES_W-1:0] w_dst_lim;
  logic               w_unused_sub_op;

  // sub_op travels with the command but has no meaning here yet.
  assign w_unused_sub_op = ^i_cmd.sub_op;

  assign w_src_ext = dim_sel(i_cmd.src_dim, i_step);
  assign w_dst_ext = dim_sel(i_cmd.dst_dim, i_step);

  // Four extents of 10 bits multiply into at most 40 bits, so no overflow.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_src_cnt <= CNT_W'(1);
      r_dst_cnt <= CNT_W'(1);
    end else if (i_start) begin
      r_src_cnt <= CNT_W'(1);
      r_dst_cnt <= CNT_W'(1);
    end else if (i_calc) begin
      r_src_cnt <= CNT_W'(r_src_cnt * {{(CNT_W-DIM_W){1'b0}}, w_src_ext});
      r_dst_cnt <= CNT_W'(r_dst_cnt * {{(CNT_W-DIM_W){1'b0}}, w_dst_ext});
    end
  end

  // Oversized shifts for invalid size codes may truncate; those commands are
  // rejected before byte counts are looked at.
  assign w_src_bytes = {3'b000, r_src_cnt} << i_cmd.in_size;
  assign w_dst_bytes = {3'b000, r_dst_cnt} << i_cmd.out_size;
  assign o_words     = (w_src_bytes + BYTES_W'(7)) >> 3;

  // Words still available between each base address and the end of buffer.
  assign w_src_lim = (BYTES_W'(1) << MEM_AW) - BYTES_W'(i_cmd.src_addr);
  assign w_dst_lim = (BYTES_W'(1) << MEM_AW) - BYTES_W'(i_cmd.dst_addr);

  always_comb begin
    o_status = STATUS_OK;
    if (!elem_size_ok(i_cmd.in_size) || !elem_size_ok(i_cmd.out_size)) begin
      o_status = STATUS_BAD_ELEM;
    end else if (w_src_bytes != w_dst_bytes) begin
      o_status = STATUS_SIZE_MISMATCH;
    end else if ((o_words > w_src_lim) || (o_words > w_dst_lim)) begin
      o_status = STATUS_RANGE;
    end
  end

endmodule

// File: rtl/bitcast_engine.sv
// -----------------------------------------------------------------------------
// bitcast_engine
// Accepts a bitcast command, validates that the source and destination views
// describe the same number of bytes and fit in the buffers, then copies whole
// 64-bit words from the source buffer to the destination buffer.
// Ports:
//   clock, reset_n                : clock, synchronous active-low reset
//   cfg_in_tdata/tvalid/tready    : command stream (bitcast_cmd_t layout)
//   src_rd_en/addr, src_rd_data   : source buffer read, data one cycle later
//   dst_wr_en/addr/data           : destination buffer write
//   done_tvalid/tready/status     : completion report, held until accepted
// -----------------------------------------------------------------------------
module bitcast_engine
  import bitcast_pkg::*;
#(
  parameter int MEM_AW = 11,
  parameter int MEM_DW = 64
)
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [CMD_W-1:0]  cfg_in_tdata,
  input  logic              cfg_in_tvalid,
  output logic              cfg_in_tready,
  output logic              src_rd_en,
  output logic [MEM_AW-1:0] src_rd_addr,
  input  logic [MEM_DW-1:0] src_rd_data,
  output logic              dst_wr_en,
  output logic [MEM_AW-1:0] dst_wr_addr,
  output logic [MEM_DW-1:0] dst_wr_data,
  output logic              done_tvalid,
  input  logic              done_tready,
  output logic [1:0]        done_status
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_CALC  = ST_CALC;
  localparam logic [2:0] S_CHECK = ST_CHECK;
  localparam logic [2:0] S_COPY  = ST_COPY;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]         r_state;
  bitcast_cmd_t       r_cmd;
  logic [1:0]         r_step;
  logic [1:0]         r_status;
  logic [MEM_AW:0]    r_words;
  logic [MEM_AW:0]    r_idx;
  logic               r_wr_en;
  logic [MEM_AW-1:0]  r_wr_addr;

  logic               w_accept;
  logic               w_rd_en;
  logic [MEM_AW-1:0]  w_src_base;
  logic [MEM_AW-1:0]  w_dst_base;
  logic [1:0]         w_calc_status;
  logic [BYTES_W-1:0] w_calc_words;

  assign w_accept   = (r_state == S_IDLE) && cfg_in_tvalid;
  assign w_src_base = MEM_AW'(r_cmd.src_addr);
  assign w_dst_base = MEM_AW'(r_cmd.dst_addr);

  // Reads run while the index is short of the word count; the extra COPY
  // cycle with the index at the count only drains the trailing write.
  assign w_rd_en = (r_state == S_COPY) && (r_idx != r_words);

  bitcast_size_calc #(
    .MEM_AW   (MEM_AW)
  ) u_size_calc (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_start  (w_accept),
    .i_calc   (r_state == S_CALC),
    .i_step   (r_step),
    .i_cmd    (r_cmd),
    .o_status (w_calc_status),
    .o_words  (w_calc_words)
  );

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_cmd <= cfg_in_tdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_step    <= 2'd0;
      r_status  <= STATUS_OK;
      r_words   <= '0;
      r_idx     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      // Write stage: each read turns into a write one cycle later, when the
      // buffer returns its data.
      r_wr_en   <= w_rd_en;
      r_wr_addr <= w_rd_en ? (w_dst_base + r_idx[MEM_AW-1:0]) : '0;

      case (r_state)
        S_IDLE: begin
          if (cfg_in_tvalid) begin
            r_step  <= 2'd0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_status <= w_calc_status;
          // A passing command has at most 2^MEM_AW words, so the narrow copy
          // of the count is exact whenever it is used.
          r_words  <= w_calc_words[MEM_AW:0];
          r_idx    <= '0;
          if ((w_calc_status != STATUS_OK) || (w_calc_words == '0)) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_COPY;
          end
        end
        S_COPY: begin
          if (w_rd_en) begin
            r_idx <= r_idx + {{MEM_AW{1'b0}}, 1'b1};
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (done_tready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_in_tready = (r_state == S_IDLE);
  assign src_rd_en     = w_rd_en;
  assign src_rd_addr   = w_rd_en ? (w_src_base + r_idx[MEM_AW-1:0]) : '0;
  assign dst_wr_en     = r_wr_en;
  assign dst_wr_addr   = r_wr_addr;
  // Buffer read data passes straight through; zero when no write is pending.
  assign dst_wr_data   = r_wr_en ? src_rd_data : '0;
  assign done_tvalid   = (r_state == S_DONE);
  assign done_status   = r_status;

endmodule

// File: tb/tb_bitcast_engine.sv
// -----------------------------------------------------------------------------
// tb_bitcast_engine
// Scoreboard bench: each issued command pushes its expected reads, writes,
// status and latency; a negedge monitor pops and compares DUT activity.
// -----------------------------------------------------------------------------
module tb_bitcast_engine;

  localparam int AW = 11;
  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [112:0]  cfg_in_tdata;
  logic          cfg_in_tvalid;
  logic          cfg_in_tready;
  logic          src_rd_en;
  logic [AW-1:0] src_rd_addr;
  logic [DW-1:0] src_rd_data;
  logic          dst_wr_en;
  logic [AW-1:0] dst_wr_addr;
  logic [DW-1:0] dst_wr_data;
  logic          done_tvalid;
  logic          done_tready;
  logic [1:0]    done_status;

  always #5 clock = ~clock;

  bitcast_engine #(.MEM_AW(AW), .MEM_DW(DW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cfg_in_tdata  (cfg_in_tdata),
    .cfg_in_tvalid (cfg_in_tvalid),
    .cfg_in_tready (cfg_in_tready),
    .src_rd_en     (src_rd_en),
    .src_rd_addr   (src_rd_addr),
    .src_rd_data   (src_rd_data),
    .dst_wr_en     (dst_wr_en),
    .dst_wr_addr   (dst_wr_addr),
    .dst_wr_data   (dst_wr_data),
    .done_tvalid   (done_tvalid),
    .done_tready   (done_tready),
    .done_status   (done_status)
  );

  // Source buffer with one-cycle read latency; garbage when not read.
  logic [63:0] src_mem [2048];
  always @(posedge clock)
    src_rd_data <= src_rd_en ? src_mem[src_rd_addr] : {$urandom, $urandom};

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          exp_rd[$];
  int          exp_wa[$];
  logic [63:0] exp_wd[$];
  int          exp_st[$];
  int          exp_lat[$];
  longint      acc_cyc = 0;
  int          hs_cnt = 0;
  bit          in_done = 0;
  int          cur_st = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (src_rd_en) begin
      if (exp_rd.size() == 0) fail_now("rd_unexpected", $sformatf("read at 0x%0h, required none", src_rd_addr));
      else chk("rd_addr", longint'(src_rd_addr), longint'(exp_rd.pop_front()));
    end
    if (dst_wr_en) begin
      if (exp_wa.size() == 0) fail_now("wr_unexpected", $sformatf("write at 0x%0h, required none", dst_wr_addr));
      else begin
        chk("wr_addr", longint'(dst_wr_addr), longint'(exp_wa.pop_front()));
        chk("wr_data", longint'(dst_wr_data), longint'(exp_wd.pop_front()));
      end
    end
    if (done_tvalid) begin
      if (!in_done) begin
        in_done = 1;
        if (exp_st.size() == 0) begin
          fail_now("done_unexpected", $sformatf("done with status %0d, required none", done_status));
          cur_st = int'(done_status);
        end else begin
          cur_st = exp_st.pop_front();
          chk("done_status", longint'(done_status), longint'(cur_st));
          chk("latency", cyc - acc_cyc, longint'(exp_lat.pop_front()));
        end
      end else begin
        chk("done_hold_status", longint'(done_status), longint'(cur_st));
        chk("tready_in_done", longint'(cfg_in_tready), 0);
      end
      if (done_tready) begin
        in_done = 0;
        chk("wr_drained", longint'(exp_wa.size()), 0);
        chk("rd_drained", longint'(exp_rd.size()), 0);
        hs_cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [39:0] dims(input int d0, input int d1, input int d2, input int d3);
    return {10'(d3), 10'(d2), 10'(d1), 10'(d0)};
  endfunction

  function automatic logic [112:0] mk(input int sub, input logic [39:0] sd, input logic [39:0] dd,
                                      input int sa, input int da, input int is, input int os);
    return {5'(sub), sd, dd, 11'(sa), 11'(da), 3'(is), 3'(os)};
  endfunction

  // Element counts as plain products, byte counts as count * element bytes.
  function automatic void ref_model(input logic [112:0] t, output int st, output longint unsigned words);
    longint unsigned sc = 1, dc = 1, sb, db;
    int is, os, sa, da;
    for (int k = 0; k < 4; k++) begin
      sc = sc * longint'(t[68 + 10*k +: 10]);
      dc = dc * longint'(t[28 + 10*k +: 10]);
    end
    sa = int'(t[27:17]); da = int'(t[16:6]);
    is = int'(t[5:3]);   os = int'(t[2:0]);
    words = 0;
    if (is > 3 || os > 3) st = 2;
    else begin
      sb = sc * (64'd1 << is);
      db = dc * (64'd1 << os);
      words = (sb + 7) / 8;
      if (sb != db) st = 1;
      else if (words > longint'(2048 - sa) || words > longint'(2048 - da)) st = 3;
      else st = 0;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [112:0] t);
    int st, sa, da, n;
    longint unsigned w;
    ref_model(t, st, w);
    sa = int'(t[27:17]); da = int'(t[16:6]);
    exp_st.push_back(st);
    exp_lat.push_back((st == 0 && w > 0) ? int'(w) + 7 : 6);
    if (st == 0)
      for (int i = 0; i < int'(w); i++) begin
        exp_rd.push_back(sa + i);
        exp_wa.push_back(da + i);
        exp_wd.push_back(src_mem[sa + i]);
      end
    @(posedge clock); #1;
    cfg_in_tdata = t; cfg_in_tvalid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!cfg_in_tready && n < 200) begin @(negedge clock); n++; end
    if (!cfg_in_tready) begin
      $display("FAIL accept_timeout: cfg_in_tready stayed 0, required 1");
      $fatal(1, "command not accepted");
    end
    acc_cyc = cyc;
    @(posedge clock); #1;
    cfg_in_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (hs_cnt < target && n < 5000) begin @(negedge clock); n++; end
    if (hs_cnt < target) fail_now("done_timeout", "no completion handshake within 5000 cycles");
  endtask

  task automatic run(input logic [112:0] t);
    int h = hs_cnt;
    send(t);
    wait_done(h + 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h, is, os, sa, da;
    logic [39:0] sd, dd;
    reset_n = 1'b0; cfg_in_tvalid = 1'b0; cfg_in_tdata = '0; done_tready = 1'b1;
    for (int i = 0; i < 2048; i++) src_mem[i] = {$urandom, $urandom};
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_tready", longint'(cfg_in_tready), 1);
    chk("rst_rd_en", longint'(src_rd_en), 0);
    chk("rst_wr_en", longint'(dst_wr_en), 0);
    chk("rst_done_tvalid", longint'(done_tvalid), 0);
    chk("rst_done_status", longint'(done_status), 0);
    chk("rst_rd_addr", longint'(src_rd_addr), 0);
    chk("rst_wr_addr", longint'(dst_wr_addr), 0);
    chk("rst_wr_data", longint'(dst_wr_data), 0);
    @(posedge clock); #1 reset_n = 1'b1;

    run(mk(3, dims(4,2,1,1), dims(4,2,1,1), 'h010, 'h100, 2, 2));   // 4 words, OK
    run(mk(0, dims(8,1,1,1), dims(2,1,1,1), 'h020, 'h200, 0, 2));   // 1 word
    run(mk(0, dims(4,1,1,1), dims(4,1,1,1), 'h030, 'h300, 2, 1));   // size differs
    run(mk(0, dims(4,1,1,1), dims(4,1,1,1), 'h030, 'h300, 5, 2));   // bad element
    run(mk(0, dims(4,1,1,1), dims(4,1,1,1), 'h7FE, 'h300, 3, 3));   // out of range
    run(mk(0, dims(4,1,1,1), dims(4,1,1,1), 'h7FC, 'h7FC, 3, 3));   // exact fit
    run(mk(0, dims(3,1,1,1), dims(3,1,1,1), 'h040, 'h400, 0, 0));   // partial word

    // zero-element command with done_tready held off
    @(posedge clock); #1 done_tready = 1'b0;
    h = hs_cnt;
    send(mk(0, dims(0,3,2,1), dims(0,5,1,1), 'h050, 'h500, 2, 2));
    n = 0;
    while (!in_done && n < 100) begin @(negedge clock); n++; end
    if (!in_done) fail_now("zero_done_timeout", "done_tvalid never rose");
    repeat (5) @(posedge clock);
    #1 done_tready = 1'b1;
    wait_done(h + 1);

    // randomized commands
    for (int r = 0; r < 30; r++) begin
      sd = dims(($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4)),
                int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
      is = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        dd = sd; os = is;
      end else begin
        dd = dims(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                  int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        os = int'($urandom_range(0, 3));
      end
      sa = int'($urandom_range(0, 2047));
      da = int'($urandom_range(0, 2047));
      run(mk(int'($urandom_range(0, 31)), sd, dd, sa, da, is, os));
    end

    // reset during the third COPY cycle of a 16-word copy
    send(mk(0, dims(16,1,1,1), dims(16,1,1,1), 'h080, 'h600, 3, 3));
    repeat (7) @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_st.delete(); exp_lat.delete();
    @(negedge clock);
    chk("tready_after_reset", longint'(cfg_in_tready), 1);
    chk("wr_after_reset", longint'(dst_wr_en), 0);
    repeat (20) @(negedge clock);

    run(mk(0, dims(2,2,1,1), dims(2,2,1,1), 'h000, 'h7F8, 3, 3));   // recovers after reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
